imm_encoder: RTL and testbench

- Streaming instruction encoder; the inverse of the decode-stage immediate extender.
- Accepts a base instruction word, an immediate value and an ImmSrc code. Scatters the immediate into the correct instruction bit positions and range-checks it.
- Emits the packed 32-bit instruction with a sequential instruction-memory address, for test-program generation and the instruction-memory loader.
- Round-trip contract: feeding InstrOut and ImmSrcIn into the decode-stage extender returns ImmIn exactly, for every legal input.

---
 rtl/imm_encoder_pkg.sv | 22 ++
 rtl/imm_pack.sv | 71 +++++++
 rtl/imm_encoder.sv | 122 ++++++++++++
 tb/tb_imm_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared constants for the instruction immediate encoder: ImmSrc codes and
// the instruction bit positions each immediate format occupies.
package imm_encoder_pkg;

    localparam int XLEN = 32;

    // Immediate format codes, identical to the decode-stage ImmSrc encoding
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_U = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Instruction bits owned by the immediate for each format; every other
    // bit is taken from the base instruction word.
    localparam logic [XLEN-1:0] MASK_I = 32'hFFF0_0000;
    localparam logic [XLEN-1:0] MASK_U = 32'hFFFF_F000;
    localparam logic [XLEN-1:0] MASK_S = 32'hFE00_0F80;
    localparam logic [XLEN-1:0] MASK_B = 32'hFE00_0F80;
    localparam logic [XLEN-1:0] MASK_J = 32'hFFFF_F000;

endpackage

// File: rtl/imm_pack.sv
// Combinational scatter of an immediate into its instruction bit positions,
// with a representability check and an ImmSrc legality check.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]      i_imm_src,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_base,
    output logic [XLEN-1:0] o_instr,
    output logic            o_range_err,
    output logic            o_src_err
);

    logic [XLEN-1:0] w_imm_bits;
    logic [XLEN-1:0] w_mask;
    logic            w_uni_12;
    logic            w_uni_20;

    // Upper bits must be a pure sign extension for the field to hold the value
    assign w_uni_12 = (&i_imm[31:11]) || !(|i_imm[31:11]);
    assign w_uni_20 = (&i_imm[31:19]) || !(|i_imm[31:19]);

    // Select the field layout and the matching range rule for each format
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        w_imm_bits  = '0;
        w_mask      = '0;
        o_range_err = 1'b0;
        o_src_err   = 1'b0;
        case (i_imm_src)
            IMM_I: begin
                w_mask            = MASK_I;
                w_imm_bits[31:20] = i_imm[11:0];
                o_range_err       = !w_uni_12;
            end
            IMM_U: begin
                w_mask            = MASK_U;
                w_imm_bits[31:12] = i_imm[31:12];
                o_range_err       = |i_imm[11:0];
            end
            IMM_S: begin
                w_mask            = MASK_S;
                w_imm_bits[31:25] = i_imm[11:5];
                w_imm_bits[11:7]  = i_imm[4:0];
                o_range_err       = !w_uni_12;
            end
            IMM_B: begin
                w_mask            = MASK_B;
                w_imm_bits[31]    = i_imm[11];
                w_imm_bits[7]     = i_imm[10];
                w_imm_bits[30:25] = i_imm[9:4];
                w_imm_bits[11:8]  = i_imm[3:0];
                o_range_err       = !w_uni_12;
            end
            IMM_J: begin
                w_mask            = MASK_J;
                w_imm_bits[31]    = i_imm[19];
                w_imm_bits[19:12] = i_imm[18:11];
                w_imm_bits[20]    = i_imm[10];
                w_imm_bits[30:21] = i_imm[9:0];
                o_range_err       = !w_uni_20;
            end
            default: begin
                o_src_err = 1'b1;
            end
        endcase
    end

    assign o_instr = (i_base & ~w_mask) | w_imm_bits;

endmodule

// File: rtl/imm_encoder.sv
// Streaming instruction encoder: packs immediates into base instructions,
// tags each legal result with a sequential word address, and tracks
// rejected requests in sticky flags and a saturating counter.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [2:0]               ImmSrcIn,
    input  logic [DATA_WIDTH-1:0]    ImmIn,
    input  logic [DATA_WIDTH-1:0]    BaseInstrIn,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_WIDTH-1:0]    InstrOut,
    output logic [ADDR_WIDTH-1:0]    AddrOut,
    output logic                     WrapPulse,
    output logic                     ErrRange,
    output logic                     ErrSrc,
    output logic [ERR_CNT_WIDTH-1:0] ErrCount,
    input  logic                     ClearErr
);

    logic [DATA_WIDTH-1:0]    w_packed;
    logic                     w_range_err;
    logic                     w_src_err;
    logic                     w_accept;
    logic                     w_legal_acc;
    logic                     w_err_acc;

    logic                     r_out_valid;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [ADDR_WIDTH-1:0]    r_cnt;
    logic                     r_wrap;
    logic                     r_err_range;
    logic                     r_err_src;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    imm_pack u_pack (
        .i_imm_src   (ImmSrcIn),
        .i_imm       (ImmIn),
        .i_base      (BaseInstrIn),
        .o_instr     (w_packed),
        .o_range_err (w_range_err),
        .o_src_err   (w_src_err)
    );

    // Illegal requests are still consumed, so readiness ignores legality
    assign InReady     = !r_out_valid || OutReady;
    assign w_accept    = InValid && InReady;
    assign w_err_acc   = w_accept && (w_range_err || w_src_err);
    assign w_legal_acc = w_accept && !w_range_err && !w_src_err;

    // Output register: load on legal accept, drop when consumed, else hold
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_out_valid <= 1'b0;
            r_instr     <= '0;
            r_addr      <= '0;
        end else if (w_legal_acc) begin
            r_out_valid <= 1'b1;
            r_instr     <= w_packed;
            r_addr      <= r_cnt;
        end else if (OutReady) begin
            r_out_valid <= 1'b0;
        end
    end

    // Address counter advances per legal accept; pulse follows the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_legal_acc && (r_cnt == '1);
            if (w_legal_acc) begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Sticky error flags and saturating drop count; a new error beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_range <= 1'b0;
            r_err_src   <= 1'b0;
            r_err_cnt   <= '0;
        end else if (w_err_acc) begin
            if (ClearErr) begin
                r_err_range <= w_range_err;
                r_err_src   <= w_src_err;
                r_err_cnt   <= ERR_CNT_WIDTH'(1);
            end else begin
                r_err_range <= r_err_range || w_range_err;
                r_err_src   <= r_err_src || w_src_err;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
                end
            end
        end else if (ClearErr) begin
            r_err_range <= 1'b0;
            r_err_src   <= 1'b0;
            r_err_cnt   <= '0;
        end
    end

    assign OutValid  = r_out_valid;
    assign InstrOut  = r_instr;
    assign AddrOut   = r_addr;
    assign WrapPulse = r_wrap;
    assign ErrRange  = r_err_range;
    assign ErrSrc    = r_err_src;
    assign ErrCount  = r_err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: packing per format with decoder round-trip,
// range/source errors, backpressure, address wrap, saturation and async reset.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        InValid;
    logic        InReady;
    logic [2:0]  ImmSrcIn;
    logic [31:0] ImmIn;
    logic [31:0] BaseInstrIn;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] InstrOut;
    logic [7:0]  AddrOut;
    logic        WrapPulse;
    logic        ErrRange;
    logic        ErrSrc;
    logic [7:0]  ErrCount;
    logic        ClearErr;

    int total = 0;
    int bad   = 0;

    imm_encoder #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (8),
        .ERR_CNT_WIDTH (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .InValid     (InValid),
        .InReady     (InReady),
        .ImmSrcIn    (ImmSrcIn),
        .ImmIn       (ImmIn),
        .BaseInstrIn (BaseInstrIn),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .InstrOut    (InstrOut),
        .AddrOut     (AddrOut),
        .WrapPulse   (WrapPulse),
        .ErrRange    (ErrRange),
        .ErrSrc      (ErrSrc),
        .ErrCount    (ErrCount),
        .ClearErr    (ClearErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference decode-stage immediate extender
    function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'b000:  decode = {{20{i[31]}}, i[31:20]};
            3'b001:  decode = {i[31:12], 12'b0};
            3'b010:  decode = {{20{i[31]}}, i[31:25], i[11:7]};
            3'b011:  decode = {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
            3'b100:  decode = {{12{i[31]}}, i[31], i[19:12], i[20], i[30:21]};
            default: decode = 32'h0;
        endcase
    endfunction

    // Present one request for one clock; called and returning at a falling edge
    task automatic send(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
        InValid     = 1'b1;
        ImmSrcIn    = src;
        ImmIn       = imm;
        BaseInstrIn = base;
        @(negedge clk);
        InValid     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; InValid = 1'b0; ImmSrcIn = 3'b000; ImmIn = '0;
        BaseInstrIn = '0; OutReady = 1'b1; ClearErr = 1'b0;
        #12;
        check("rst_valid", OutValid, 0);
        check("rst_instr", InstrOut, 0);
        check("rst_addr", AddrOut, 0);
        check("rst_wrap", WrapPulse, 0);
        check("rst_errs", {ErrRange, ErrSrc}, 0);
        check("rst_errcnt", ErrCount, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Packing for each format, back-to-back
        send(3'b000, 32'hFFFF_FFFF, 32'h0000_0093);
        check("i_valid", OutValid, 1);
        check("i_instr", InstrOut, 32'hFFF0_0093);
        check("i_addr", AddrOut, 0);
        check("i_rt", decode(InstrOut, 3'b000), 32'hFFFF_FFFF);
        send(3'b011, 32'hFFFF_F800, 32'h0000_0063);
        check("b_instr", InstrOut, 32'h8000_0063);
        check("b_addr", AddrOut, 1);
        check("b_rt", decode(InstrOut, 3'b011), 32'hFFFF_F800);
        send(3'b010, 32'hFFFF_F9A5, 32'h0000_2023);
        check("s_instr", InstrOut, 32'h9A00_22A3);
        check("s_addr", AddrOut, 2);
        check("s_rt", decode(InstrOut, 3'b010), 32'hFFFF_F9A5);
        send(3'b001, 32'h1234_5000, 32'h0000_0037);
        check("u_instr", InstrOut, 32'h1234_5037);
        check("u_addr", AddrOut, 3);

        // J out of range: dropped while the previous output drains
        send(3'b100, 32'h0008_0000, 32'h0000_006F);
        check("j_bad_valid", OutValid, 0);
        check("j_bad_range", ErrRange, 1);
        check("j_bad_cnt", ErrCount, 1);
        send(3'b100, 32'hFFF8_0000, 32'h0000_006F);
        check("j_valid", OutValid, 1);
        check("j_instr", InstrOut, 32'h8000_006F);
        check("j_addr", AddrOut, 4);
        check("j_rt", decode(InstrOut, 3'b100), 32'hFFF8_0000);

        // Illegal source and U low bits set
        send(3'b101, 32'h0, 32'h0000_0013);
        check("src_flag", ErrSrc, 1);
        check("src_valid", OutValid, 0);
        check("src_cnt", ErrCount, 2);
        send(3'b001, 32'h1234_5001, 32'h0000_0037);
        check("u_bad_valid", OutValid, 0);
        check("u_bad_cnt", ErrCount, 3);

        // Clear together with a new error: the new error wins
        ClearErr = 1'b1;
        send(3'b110, 32'h0, 32'h0000_0013);
        ClearErr = 1'b0;
        check("clr_err_src", ErrSrc, 1);
        check("clr_err_range", ErrRange, 0);
        check("clr_err_cnt", ErrCount, 1);
        send(3'b000, 32'h0000_0005, 32'h0000_0013);
        check("post_err_addr", AddrOut, 5);
        check("post_err_instr", InstrOut, 32'h0050_0013);
        ClearErr = 1'b1;
        @(negedge clk);
        ClearErr = 1'b0;
        check("clr_flags", {ErrRange, ErrSrc}, 0);
        check("clr_cnt", ErrCount, 0);
        check("clr_drained", OutValid, 0);

        // Backpressure: hold for three cycles, then release
        OutReady = 1'b0;
        send(3'b000, 32'h1, 32'h0000_0013);
        check("bp_a_valid", OutValid, 1);
        check("bp_a_addr", AddrOut, 6);
        InValid = 1'b1; ImmIn = 32'h2;
        for (int k = 0; k < 3; k++) begin
            check("bp_ready", InReady, 0);
            check("bp_hold_instr", InstrOut, 32'h0010_0013);
            check("bp_hold_addr", AddrOut, 6);
            @(negedge clk);
        end
        OutReady = 1'b1;
        #1;
        check("bp_release_ready", InReady, 1);
        @(negedge clk);
        InValid = 1'b0;
        check("bp_b_valid", OutValid, 1);
        check("bp_b_instr", InstrOut, 32'h0020_0013);
        check("bp_b_addr", AddrOut, 7);
        @(negedge clk);
        check("bp_drained", OutValid, 0);

        // Asynchronous reset while an output is stalled and an error is latched
        OutReady = 1'b0;
        send(3'b111, 32'h0, 32'h0000_0013);
        send(3'b000, 32'h3, 32'h0000_0013);
        check("pre_rst_valid", OutValid, 1);
        check("pre_rst_errsrc", ErrSrc, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", OutValid, 0);
        check("arst_addr", AddrOut, 0);
        check("arst_instr", InstrOut, 0);
        check("arst_errs", {ErrRange, ErrSrc}, 0);
        check("arst_cnt", ErrCount, 0);
        @(negedge clk);
        rst = 1'b0;
        OutReady = 1'b1;
        @(negedge clk);

        // 256 consecutive legal requests from a freshly reset counter
        InValid = 1'b1; ImmSrcIn = 3'b000; BaseInstrIn = 32'h0000_0013;
        for (int i = 0; i < 256; i++) begin
            ImmIn = 32'(i);
            @(negedge clk);
            check("wrap_addr", AddrOut, 32'(i));
            check("wrap_pulse", WrapPulse, (i == 255) ? 32'd1 : 32'd0);
        end
        ImmIn = 32'h0;
        @(negedge clk);
        InValid = 1'b0;
        check("wrap_next_addr", AddrOut, 0);
        check("wrap_pulse_gone", WrapPulse, 0);

        // Drop counter saturates at all-ones
        InValid = 1'b1; ImmSrcIn = 3'b101;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
        end
        InValid = 1'b0;
        check("sat_cnt", ErrCount, 32'hFF);
        check("sat_valid", OutValid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
